// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the up/down modulo counter: default parameter
// values, the direction encoding and the prescale counter width helper.
package mod_updown_counter_pkg;

  localparam int unsigned     DEF_WIDTH    = 4;
  localparam longint unsigned DEF_MODULUS  = 10;
  localparam int unsigned     DEF_PRESCALE = 1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Width of the prescale counter: enough to hold PRESCALE-1, never below 1 bit.
  function automatic int unsigned psc_width(input int unsigned prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/mod_updown_counter_prescaler.sv
// Prescaler for the modulo counter: counts enabled falling edges and flags
// the edge on which a count step is due. A clear or load restarts the period.
module mod_prescaler
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic load,
  output logic step_due
);

  localparam int unsigned   CW   = psc_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("mod_prescaler: PRESCALE must be in 1..256");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next prescale count and step flag; clr/load win over counting.
  always_comb begin
    step_due = 1'b0;
    cnt_d    = cnt_q;
    if (clr || load) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        step_due = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Prescale counter register, falling-edge clocked, async active-low reset.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with prescaler, synchronous clear and
// clamped load, combinational terminal count and a registered wrap pulse.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEF_WIDTH,
  parameter longint unsigned MODULUS  = DEF_MODULUS,
  parameter int unsigned     PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  // Last state kept one bit wider so MODULUS == 2**WIDTH compares cleanly.
  localparam logic [WIDTH:0]   LAST_EXT = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LAST     = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             step_due;
  logic             at_last;
  logic             tc_int;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   load_ext;
  dir_e             dir;

  assign dir = dir_e'(up);

  mod_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .step_due (step_due)
  );

  // Next count, terminal count and wrap; priority is clr, then load, then step.
  always_comb begin
    q_ext    = {1'b0, q_q};
    load_ext = {1'b0, load_val};
    at_last  = (dir == DIR_UP) ? (q_ext == LAST_EXT) : (q_ext == '0);
    tc_int   = step_due & at_last;
    q_d      = q_q;
    wrap_d   = tc_int;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = (load_ext > LAST_EXT) ? LAST : load_val;
    end else if (step_due) begin
      if (dir == DIR_UP) begin
        q_d = at_last ? '0 : WIDTH'(q_ext + (WIDTH + 1)'(1));
      end else begin
        q_d = at_last ? LAST : WIDTH'(q_ext - (WIDTH + 1)'(1));
      end
    end
  end

  // Count and wrap registers, falling-edge clocked, async active-low reset.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_int;
  assign wrap = wrap_q;

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down modulo counter; next generation of the team's 2-bit T-flip-flop ripple counter.
- Adds generic width and modulus, direction control, count enable, synchronous clear and load, terminal-count flag and a registered wrap pulse.
- Intended as the standard counter primitive for dividers, timers and sequencers in lab designs.

Parameters:
- WIDTH, 4, bit width of the count value (1..32).
- MODULUS, 10, number of states; count runs 0..MODULUS-1. Legal range is 2..2**WIDTH; elaboration error otherwise.
- PRESCALE, 1, number of enabled clk edges per count step (1..256); 1 means step every enabled edge.

Ports:
- clk  input  1  clock; all state updates on the falling edge of clk.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: q at last state in current direction AND step due this edge.
- wrap  output  1  registered one-cycle pulse after a wrap occurred.

Behaviour:
- Reset low (asynchronous): q=0, wrap=0, prescale counter=0 immediately; held while low. Release is sampled at the next falling clk edge.
- Priority per falling edge: clr > load > en.
- clr=1: q<=0; prescale counter<=0; wrap<=0.
- load=1 (clr=0): q<=load_val if load_val<MODULUS, else q<=MODULUS-1 (clamped); prescale counter<=0; wrap<=0.
- en=1, no clr/load: prescale counter increments. When it reaches PRESCALE-1, a step is due; the counter returns to 0.
- Step, up=1: q<=q+1, or 0 if q==MODULUS-1.
- Step, up=0: q<=q-1, or MODULUS-1 if q==0.
- en=0: q and prescale counter hold; wrap<=0.
- tc=1 iff en=1, clr=0, load=0, a step is due, and q is at its last state (MODULUS-1 for up, 0 for down).
- wrap<=tc on every falling edge. It is high for exactly one cycle after each wrap step.
- Changing up mid-count: takes effect on the next step with no extra latency. tc is evaluated against the current up value.
- Arithmetic: compare and increment at WIDTH+1 bits internally. With MODULUS=2**WIDTH, natural roll-over must equal modulo wrap.
- Latency: q updates at the same falling edge the step is taken. wrap lags tc by one edge.
- Reset mid-operation: all state, including the prescale counter, returns to 0 with no partial step. The first step after release needs the full PRESCALE enabled edges.

Decomposition:
- Shared include file: default WIDTH/MODULUS/PRESCALE constants and the prescale counter width macro (clog2 of PRESCALE, minimum 1).
- One sub-module is natural: mod_prescaler. It holds the PRESCALE counter and emits step_due, with clr/load/en inputs and the same clk/reset.
- Wrap and next-count logic live in the top module.

Test Plan:
- Reset and count-up (WIDTH=4, MODULUS=10, PRESCALE=1): reset low 20 ns then high, en=1, up=1 -> q 0,1,...,9,0. tc=1 while q=9. wrap=1 for the single cycle with q=0 after the wrap.
- Count-down wrap: load_val=2, load pulse, then en=1, up=0 -> q 2,1,0,9,8. tc high at q=0. wrap high with q=9.
- Load clamp and priority: load_val=13 -> q=9. Assert clr and load together with load_val=5 -> q=0. load with en=1 and load_val=5 -> q=5 with no step.
- Prescale (PRESCALE=3): en=1, up=1 from q=0 -> q increments every 3rd falling edge. Drop en for 2 edges mid-period -> period resumes with no lost or extra step.
- Async reset mid-count: reset low between clk edges at q=7 -> q=0 and wrap=0 immediately without a clk edge. After release, the first step occurs after PRESCALE enabled edges.
- Full-range (WIDTH=3, MODULUS=8): up from 7 -> 0 and down from 0 -> 7. tc and wrap are correct with no X or overflow.
